// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: a chain of DEPTH elastic pipeline registers, each WIDTH bits wide.
//
// Each stage has a valid bit and a data register. Items move forward under a
// valid/ready handshake. The ready chain is combinational from out_ready_i back
// to in_ready_o, so there is no skid buffer and throughput stays at one item per
// cycle. Each stage can be held (stalled) or flushed (killed) on its own.
//
// Ports:
//   clk_i          clock; all state updates on the rising edge
//   rst_i          asynchronous reset, active-low
//   in_valid_i     producer offers in_data_i
//   in_ready_o     stage 0 accepts this cycle
//   in_data_i      payload into stage 0
//   out_valid_o    last stage holds a live (unflushed) item
//   out_ready_i    consumer takes the output item
//   out_data_o     payload of the last stage
//   hold_i         bit k: stage k must not advance this cycle
//   flush_i        bit k: kill the start-of-cycle item in stage k
//   stage_valid_o  registered valid bit per stage
//   stage_data_o   registered data per stage, stage k at [k*WIDTH +: WIDTH]
//   occupancy_o    popcount of stage_valid_o
//   drop_cnt_o     saturating count of valid items killed by flush
module pipe_stage_chain #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DROP_W = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [WIDTH-1:0]             out_data_o,
  input  logic [DEPTH-1:0]             hold_i,
  input  logic [DEPTH-1:0]             flush_i,
  output logic [DEPTH-1:0]             stage_valid_o,
  output logic [DEPTH*WIDTH-1:0]       stage_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
  output logic [DROP_W-1:0]            drop_cnt_o
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);
  localparam int unsigned SumW = ((DROP_W > OccW) ? DROP_W : OccW) + 1;

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [DEPTH:0]   acc;
  logic [DEPTH-1:0] ev, mv, ld;
  logic [OccW-1:0]  occ, kill_cnt;
  logic [SumW-1:0]  drop_sum;

  // Handshake chain, walked from the output back to the input.
  always_comb begin
    acc        = '0;
    ev         = '0;
    mv         = '0;
    acc[DEPTH] = out_ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ev[k]  = v_q[k] & ~flush_i[k];
      mv[k]  = ev[k] & ~hold_i[k] & acc[k+1];
      acc[k] = ~ev[k] | mv[k];
    end
  end

  // Next-state: a stage either loads from upstream or keeps its surviving item.
  // An item moving into a flushed stage is kept; flush only kills old contents.
  always_comb begin
    ld    = '0;
    ld[0] = in_valid_i & acc[0];
    for (int k = 1; k < DEPTH; k++) begin
      ld[k] = mv[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      v_d[k] = ld[k] | (ev[k] & ~mv[k]);
      d_d[k] = d_q[k];
    end
    if (ld[0]) d_d[0] = in_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      if (ld[k]) d_d[k] = d_q[k-1];
    end
  end

  // Occupancy and drop counting.
  always_comb begin
    occ      = '0;
    kill_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ      = occ + OccW'(v_q[k]);
      kill_cnt = kill_cnt + OccW'(v_q[k] & flush_i[k]);
    end
    drop_sum = SumW'(drop_q) + SumW'(kill_cnt);
    // Saturate instead of wrapping.
    if (drop_sum > SumW'({DROP_W{1'b1}})) drop_d = '1;
    else                                  drop_d = drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      v_q    <= '0;
      drop_q <= '0;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= '0;
    end else begin
      v_q    <= v_d;
      drop_q <= drop_d;
      for (int k = 0; k < DEPTH; k++) d_q[k] <= d_d[k];
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_data_o[k*WIDTH +: WIDTH] = d_q[k];
    end
  end

  assign in_ready_o    = acc[0];
  assign out_valid_o   = ev[DEPTH-1];
  assign out_data_o    = d_q[DEPTH-1];
  assign stage_valid_o = v_q;
  assign occupancy_o   = occ;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain (DEPTH=4, WIDTH=32, DROP_W=4). Stimulus pushes each
// accepted payload into a queue; a monitor pops and compares on every output
// transfer.
module tb_pipe_stage_chain;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned DW = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            in_valid_i;
  logic            in_ready_o;
  logic [W-1:0]    in_data_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [W-1:0]    out_data_o;
  logic [D-1:0]    hold_i;
  logic [D-1:0]    flush_i;
  logic [D-1:0]    stage_valid_o;
  logic [D*W-1:0]  stage_data_o;
  logic [2:0]      occupancy_o;
  logic [DW-1:0]   drop_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q [$];

  pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .DROP_W(DW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_data_i    (in_data_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_data_o   (out_data_o),
    .hold_i       (hold_i),
    .flush_i      (flush_i),
    .stage_valid_o(stage_valid_o),
    .stage_data_o (stage_data_o),
    .occupancy_o  (occupancy_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer happens when the last stage is live, not held, and the
  // consumer is ready.
  always @(negedge clk) begin
    if (rst_i && out_valid_o && out_ready_i && !hold_i[D-1]) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected nothing", out_data_o);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data_o !== e) begin
          n_fail++;
          $display("FAIL out_data: got %0h expected %0h", out_data_o, e);
        end
      end
    end
  end

  // One clock: record an input handshake mid-cycle, end 1 unit after the edge.
  task automatic cycle();
    @(negedge clk);
    if (in_valid_i && in_ready_o) exp_q.push_back(in_data_i);
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] data);
    in_valid_i = 1'b1;
    in_data_i  = data;
    cycle();
    in_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [3:0] exp_drop;
    rst_i = 1'b0; in_valid_i = 1'b0; in_data_i = '0; out_ready_i = 1'b0;
    hold_i = '0; flush_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stage_valid", 64'(stage_valid_o), 64'h0);
    chk("rst_out_valid", 64'(out_valid_o), 64'h0);
    chk("rst_out_data", 64'(out_data_o), 64'h0);
    chk("rst_occupancy", 64'(occupancy_o), 64'h0);
    chk("rst_drop", 64'(drop_cnt_o), 64'h0);
    chk("rst_in_ready", 64'(in_ready_o), 64'h1);
    rst_i = 1'b1;

    // Mid-stream asynchronous reset.
    out_ready_i = 1'b1;
    push(32'h0000_0001); push(32'h0000_0002); push(32'h0000_0003);
    chk("pre_rst_valid", 64'(stage_valid_o), 64'h7);
    #2 rst_i = 1'b0;
    #1;
    chk("midrst_stage_valid", 64'(stage_valid_o), 64'h0);
    chk("midrst_out_valid", 64'(out_valid_o), 64'h0);
    chk("midrst_occupancy", 64'(occupancy_o), 64'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_i = 1'b1;
    #1;
    chk("postrst_in_ready", 64'(in_ready_o), 64'h1);

    // Stream: three items back-to-back, first output 4 cycles after accept.
    push(32'h1111_1111);
    chk("lat_e1", 64'(out_valid_o), 64'h0);
    push(32'h2222_2222);
    push(32'h3333_3333);
    chk("lat_e3", 64'(out_valid_o), 64'h0);
    idle(1);
    chk("lat_e4_valid", 64'(out_valid_o), 64'h1);
    chk("lat_e4_data", 64'(out_data_o), 64'h1111_1111);
    idle(3);
    chk("stream_drained", 64'(occupancy_o), 64'h0);
    chk("stream_queue", 64'(exp_q.size()), 64'h0);

    // Backpressure: fill with out_ready low, fifth item refused.
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) push(32'hB000_0000 + 32'(i));
    in_valid_i = 1'b1; in_data_i = 32'hB000_0005;
    #1;
    chk("bp_in_ready", 64'(in_ready_o), 64'h0);
    chk("bp_occupancy", 64'(occupancy_o), 64'h4);
    cycle();
    // Last stage held: output stays valid but nothing is consumed.
    out_ready_i = 1'b1; hold_i = 4'b1000;
    #1;
    chk("hold3_out_valid", 64'(out_valid_o), 64'h1);
    chk("hold3_in_ready", 64'(in_ready_o), 64'h0);
    cycle();
    hold_i = '0;
    #1;
    chk("bp_release_ready", 64'(in_ready_o), 64'h1);
    cycle();
    chk("bp_full_again", 64'(occupancy_o), 64'h4);
    idle(6);
    chk("bp_drained", 64'(occupancy_o), 64'h0);
    chk("bp_queue", 64'(exp_q.size()), 64'h0);

    // Hold on stage 1 for one cycle in a full-rate stream.
    push(32'hC000_0001); push(32'hC000_0002); push(32'hC000_0003);
    in_valid_i = 1'b1; in_data_i = 32'hC000_0004; hold_i = 4'b0010;
    #1;
    chk("hold_in_ready", 64'(in_ready_o), 64'h0);
    cycle();
    hold_i = '0;
    chk("hold_bubble", 64'(stage_valid_o), 64'b1011);
    push(32'hC000_0004); push(32'hC000_0005); push(32'hC000_0006);
    idle(7);
    chk("hold_drained", 64'(occupancy_o), 64'h0);
    chk("hold_queue", 64'(exp_q.size()), 64'h0);

    // Flush stages 0..2 of a full chain while loading a new item.
    out_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) push(32'hD000_0000 + 32'(i));
    out_ready_i = 1'b1; flush_i = 4'b0111;
    in_valid_i = 1'b1; in_data_i = 32'hAAAA_0000;
    repeat (3) void'(exp_q.pop_back());
    cycle();
    in_valid_i = 1'b0; flush_i = '0;
    chk("flush_valid", 64'(stage_valid_o), 64'b0001);
    chk("flush_data0", 64'(stage_data_o[W-1:0]), 64'hAAAA_0000);
    chk("flush_drop", 64'(drop_cnt_o), 64'h3);
    idle(5);
    chk("flush_queue", 64'(exp_q.size()), 64'h0);

    // Flushing an empty chain adds nothing.
    flush_i = 4'b1111;
    cycle();
    flush_i = '0;
    chk("flush_empty_drop", 64'(drop_cnt_o), 64'h3);

    // Saturation: 3 -> 7 -> 11 -> 15 -> 15.
    exp_drop = 4'h3;
    for (int r = 0; r < 4; r++) begin
      out_ready_i = 1'b0;
      for (int i = 1; i <= 4; i++) push(32'hE000_0000 + 32'(r * 16 + i));
      flush_i = 4'b1111;
      repeat (4) void'(exp_q.pop_back());
      cycle();
      flush_i = '0;
      exp_drop = (exp_drop > 4'd11) ? 4'hF : exp_drop + 4'd4;
      chk("sat_drop", 64'(drop_cnt_o), 64'(exp_drop));
      chk("sat_occupancy", 64'(occupancy_o), 64'h0);
    end
    chk("sat_final", 64'(drop_cnt_o), 64'hF);
    chk("final_queue", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
